mesi_isc_cbus_snoop_resp: RTL and testbench

// CPU-side end of the coherence bus: one instance per CPU port of the broadcast unit. Accepts the

---
 rtl/mesi_isc_pkg.sv | 44 ++++
 rtl/mesi_isc_snoop_tag_array.sv | 47 ++++
 rtl/mesi_isc_cbus_snoop_resp.sv | 176 +++++++++++++++++
 tb/tb_mesi_isc_cbus_snoop_resp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared types for the coherence-bus snoop responder: bus commands, MESI states,
// responder FSM states and the line-state table entry.
package mesi_isc_pkg;

    localparam int LINE_TAG_WIDTH = 27;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_WR_SNOOP = 3'd1,
        CMD_RD_SNOOP = 3'd2,
        CMD_EN_WR    = 3'd3,
        CMD_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2,
        ST_M = 2'd3
    } mesi_state_e;

    typedef enum logic [2:0] {
        FSM_IDLE     = 3'd0,
        FSM_LOOKUP   = 3'd1,
        FSM_WB       = 3'd2,
        FSM_GRANT    = 3'd3,
        FSM_ACK      = 3'd4,
        FSM_WAIT_NOP = 3'd5
    } snoop_fsm_e;

    typedef struct packed {
        logic [LINE_TAG_WIDTH-1:0] tag;
        mesi_state_e               state;
    } line_entry_t;

    function automatic logic is_active_cmd(input logic [2:0] cmd);
        return (cmd >= 3'd1) && (cmd <= 3'd4);
    endfunction

    function automatic logic is_reserved_cmd(input logic [2:0] cmd);
        return cmd > 3'd4;
    endfunction

endpackage

// File: rtl/mesi_isc_snoop_tag_array.sv
// Direct-mapped MESI line-state table: one write port, a registered lookup port
// and a combinational debug port; cleared to all-invalid by reset.
module mesi_isc_snoop_tag_array
    import mesi_isc_pkg::*;
#(
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  line_entry_t            wr_entry,
    input  logic                   rd_en,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output line_entry_t            rd_entry,
    input  logic [INDEX_WIDTH-1:0] dbg_index,
    output line_entry_t            dbg_entry
);
    localparam int DEPTH = 1 << INDEX_WIDTH;

    line_entry_t mem_r [DEPTH];
    line_entry_t rd_entry_r;

    // Table storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[wr_index] <= wr_entry;
        end
    end

    // Lookup data is captured when a command is accepted and used one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_entry_r <= '0;
        end else if (rd_en) begin
            rd_entry_r <= mem_r[rd_index];
        end
    end

    assign rd_entry  = rd_entry_r;
    assign dbg_entry = mem_r[dbg_index];

endmodule

// File: rtl/mesi_isc_cbus_snoop_resp.sv
// CPU-side coherence-bus endpoint: services snoops (with writeback of M lines) and
// grants the local CPU's pending accesses, acknowledging each command once.
module mesi_isc_cbus_snoop_resp
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 2,
    parameter int INDEX_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    output logic                      cbus_ack_o,
    output logic                      wb_req_o,
    output logic [ADDR_WIDTH-1:0]     wb_addr_o,
    input  logic                      wb_ack_i,
    output logic                      en_valid_o,
    output logic                      en_wr_o,
    output logic [ADDR_WIDTH-1:0]     en_addr_o,
    input  logic                      en_ready_i,
    input  logic [ADDR_WIDTH-1:0]     dbg_addr_i,
    output logic [1:0]                dbg_state_o,
    output logic                      proto_err_o
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    snoop_fsm_e            state_r, state_next_s;
    cbus_cmd_e             cmd_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    mesi_state_e           new_state_r, new_state_s;
    logic                  ack_r, wb_req_r, en_valid_r, en_wr_r, proto_err_r;
    logic                  accept_s, busy_s, hit_s, err_event_s, tbl_we_s, unused_dbg_offset_s;
    logic [TAG_WIDTH-1:0]  addr_tag_s, dbg_tag_s;
    line_entry_t           rd_entry_s, dbg_entry_s, tbl_wr_entry_s;

    assign accept_s   = (state_r == FSM_IDLE) && is_active_cmd(cbus_cmd_i);
    assign busy_s     = (state_r == FSM_LOOKUP) || (state_r == FSM_WB) ||
                        (state_r == FSM_GRANT)  || (state_r == FSM_ACK);
    assign addr_tag_s = addr_r[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign dbg_tag_s  = dbg_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign hit_s      = (rd_entry_s.state != ST_I) && (rd_entry_s.tag == addr_tag_s);
    assign err_event_s = is_reserved_cmd(cbus_cmd_i) ||
                         (busy_s && ((cbus_cmd_i != cmd_r) || (cbus_addr_i != addr_r)));
    assign unused_dbg_offset_s = ^dbg_addr_i[OFFSET_WIDTH-1:0];

    mesi_isc_snoop_tag_array #(.INDEX_WIDTH(INDEX_WIDTH)) u_tag_array (
        .clk       (clk),
        .rst       (rst),
        .we        (tbl_we_s),
        .wr_index  (addr_r[OFFSET_WIDTH +: INDEX_WIDTH]),
        .wr_entry  (tbl_wr_entry_s),
        .rd_en     (accept_s),
        .rd_index  (cbus_addr_i[OFFSET_WIDTH +: INDEX_WIDTH]),
        .rd_entry  (rd_entry_s),
        .dbg_index (dbg_addr_i[OFFSET_WIDTH +: INDEX_WIDTH]),
        .dbg_entry (dbg_entry_s)
    );

    // Next-state and table-write decode.
    always_comb begin
        state_next_s         = state_r;
        new_state_s          = new_state_r;
        tbl_we_s             = 1'b0;
        tbl_wr_entry_s.tag   = addr_tag_s;
        tbl_wr_entry_s.state = ST_I;
        case (state_r)
            FSM_IDLE: begin
                if (accept_s) state_next_s = FSM_LOOKUP;
                else          state_next_s = FSM_IDLE;
            end
            FSM_LOOKUP: begin
                case (cmd_r)
                    CMD_WR_SNOOP: begin
                        new_state_s = ST_I;
                        if (hit_s && (rd_entry_s.state == ST_M)) begin
                            state_next_s = FSM_WB;
                        end else if (hit_s) begin
                            tbl_we_s     = 1'b1;
                            state_next_s = FSM_ACK;
                        end else begin
                            state_next_s = FSM_ACK;
                        end
                    end
                    CMD_RD_SNOOP: begin
                        new_state_s = ST_S;
                        if (hit_s && (rd_entry_s.state == ST_M)) begin
                            state_next_s = FSM_WB;
                        end else if (hit_s && (rd_entry_s.state == ST_E)) begin
                            tbl_we_s             = 1'b1;
                            tbl_wr_entry_s.state = ST_S;
                            state_next_s         = FSM_ACK;
                        end else begin
                            state_next_s = FSM_ACK;
                        end
                    end
                    CMD_EN_WR, CMD_EN_RD: state_next_s = FSM_GRANT;
                    default:              state_next_s = FSM_ACK;
                endcase
            end
            FSM_WB: begin
                if (wb_ack_i) begin
                    tbl_we_s             = 1'b1;
                    tbl_wr_entry_s.state = new_state_r;
                    state_next_s         = FSM_ACK;
                end else begin
                    state_next_s = FSM_WB;
                end
            end
            FSM_GRANT: begin
                // Installing overwrites whatever victim held the index.
                if (en_ready_i) begin
                    tbl_we_s             = 1'b1;
                    tbl_wr_entry_s.state = en_wr_r ? ST_M : ST_S;
                    state_next_s         = FSM_ACK;
                end else begin
                    state_next_s = FSM_GRANT;
                end
            end
            FSM_ACK: state_next_s = FSM_WAIT_NOP;
            FSM_WAIT_NOP: begin
                if ((cbus_cmd_i == CMD_NOP) || is_reserved_cmd(cbus_cmd_i)) state_next_s = FSM_IDLE;
                else                                                         state_next_s = FSM_WAIT_NOP;
            end
            default: state_next_s = FSM_IDLE;
        endcase
    end

    // State, latched command and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FSM_IDLE;
            cmd_r       <= CMD_NOP;
            addr_r      <= '0;
            new_state_r <= ST_I;
            ack_r       <= 1'b0;
            wb_req_r    <= 1'b0;
            en_valid_r  <= 1'b0;
            en_wr_r     <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            new_state_r <= new_state_s;
            ack_r       <= (state_next_s == FSM_ACK);
            wb_req_r    <= (state_next_s == FSM_WB);
            en_valid_r  <= (state_next_s == FSM_GRANT);
            if (accept_s) begin
                cmd_r   <= cbus_cmd_e'(cbus_cmd_i);
                addr_r  <= cbus_addr_i;
                en_wr_r <= (cbus_cmd_i == CMD_EN_WR);
            end
            if (err_event_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // Debug view: invalid on a tag miss.
    always_comb begin
        if ((dbg_entry_s.state != ST_I) && (dbg_entry_s.tag == dbg_tag_s)) begin
            dbg_state_o = dbg_entry_s.state;
        end else begin
            dbg_state_o = ST_I;
        end
    end

    assign cbus_ack_o  = ack_r;
    assign wb_req_o    = wb_req_r;
    assign wb_addr_o   = {addr_r[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign en_valid_o  = en_valid_r;
    assign en_wr_o     = en_wr_r;
    assign en_addr_o   = addr_r;
    assign proto_err_o = proto_err_r;

endmodule

// File: tb/tb_mesi_isc_cbus_snoop_resp.sv
// Directed-vector bench for the coherence-bus snoop responder.
module tb_mesi_isc_cbus_snoop_resp;

    localparam logic [2:0] NOP = 3'd0, WRS = 3'd1, RDS = 3'd2, ENW = 3'd3, ENR = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cbus_addr_i = 32'd0;
    logic [2:0]  cbus_cmd_i = 3'd0;
    logic        cbus_ack_o, wb_req_o, en_valid_o, en_wr_o, proto_err_o;
    logic [31:0] wb_addr_o, en_addr_o;
    logic        wb_ack_i = 1'b0;
    logic        en_ready_i = 1'b0;
    logic [31:0] dbg_addr_i = 32'd0;
    logic [1:0]  dbg_state_o;

    int vectors = 0;
    int miscompares = 0;

    mesi_isc_cbus_snoop_resp dut (
        .clk(clk), .rst(rst), .cbus_addr_i(cbus_addr_i), .cbus_cmd_i(cbus_cmd_i),
        .cbus_ack_o(cbus_ack_o), .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i),
        .en_valid_o(en_valid_o), .en_wr_o(en_wr_o), .en_addr_o(en_addr_o), .en_ready_i(en_ready_i),
        .dbg_addr_i(dbg_addr_i), .dbg_state_o(dbg_state_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts negedges from the drive point until ack is seen; -1 if the budget expires.
    task automatic wait_ack(input int limit, output int cycles);
        int n = 0;
        while (cbus_ack_o !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        cycles = (cbus_ack_o === 1'b1) ? n : -1;
    endtask

    task automatic drop_cmd();
        tick();
        cbus_cmd_i = NOP;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        dbg_addr_i = 32'h40; #1;
        vectors++; if (cbus_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", cbus_ack_o); end
        vectors++; if (wb_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_wb_req: got %b want 0", wb_req_o); end
        vectors++; if (en_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_en_valid: got %b want 0", en_valid_o); end
        vectors++; if (proto_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_proto_err: got %b want 0", proto_err_o); end
        vectors++; if (dbg_state_o !== 2'd0) begin miscompares++; $display("FAIL rst_dbg_state: got %0d want 0", dbg_state_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rd_snoop_miss();
        int cyc;
        cbus_addr_i = 32'h40; cbus_cmd_i = RDS;
        wait_ack(10, cyc);
        vectors++; if (cyc != 2) begin miscompares++; $display("FAIL rdmiss_latency: got %0d want 2", cyc); end
        vectors++; if (wb_req_o !== 1'b0) begin miscompares++; $display("FAIL rdmiss_wb_req: got %b want 0", wb_req_o); end
        tick();
        vectors++; if (cbus_ack_o !== 1'b0) begin miscompares++; $display("FAIL rdmiss_ack_width: got %b want 0", cbus_ack_o); end
        cbus_cmd_i = NOP;
        tick();
        dbg_addr_i = 32'h40; #1;
        vectors++; if (dbg_state_o !== 2'd0) begin miscompares++; $display("FAIL rdmiss_state: got %0d want 0", dbg_state_o); end
    endtask

    task automatic test_en_wr_grant();
        int n = 0;
        cbus_addr_i = 32'h40; cbus_cmd_i = ENW;
        tick();
        vectors++; if (en_valid_o !== 1'b0) begin miscompares++; $display("FAIL enwr_lookup_valid: got %b want 0", en_valid_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            if (en_valid_o === 1'b1 && en_wr_o === 1'b1 && en_addr_o === 32'h40 && cbus_ack_o === 1'b0) n++;
            if (i == 2) en_ready_i = 1'b1;
            tick();
        end
        en_ready_i = 1'b0;
        vectors++; if (n != 3) begin miscompares++; $display("FAIL enwr_grant_cycles: got %0d want 3", n); end
        vectors++; if (cbus_ack_o !== 1'b1) begin miscompares++; $display("FAIL enwr_ack: got %b want 1", cbus_ack_o); end
        vectors++; if (en_valid_o !== 1'b0) begin miscompares++; $display("FAIL enwr_valid_drop: got %b want 0", en_valid_o); end
        dbg_addr_i = 32'h40; #1;
        vectors++; if (dbg_state_o !== 2'd3) begin miscompares++; $display("FAIL enwr_state: got %0d want 3", dbg_state_o); end
        drop_cmd();
    endtask

    task automatic test_rd_snoop_wb();
        int n = 0;
        cbus_addr_i = 32'h43; cbus_cmd_i = RDS;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            if (wb_req_o === 1'b1 && wb_addr_o === 32'h40 && cbus_ack_o === 1'b0) n++;
            if (i == 3) wb_ack_i = 1'b1;
            tick();
        end
        wb_ack_i = 1'b0;
        vectors++; if (n != 4) begin miscompares++; $display("FAIL wb_held_cycles: got %0d want 4", n); end
        vectors++; if (cbus_ack_o !== 1'b1) begin miscompares++; $display("FAIL wb_ack: got %b want 1", cbus_ack_o); end
        vectors++; if (wb_req_o !== 1'b0) begin miscompares++; $display("FAIL wb_req_drop: got %b want 0", wb_req_o); end
        dbg_addr_i = 32'h40; #1;
        vectors++; if (dbg_state_o !== 2'd1) begin miscompares++; $display("FAIL wb_state: got %0d want 1", dbg_state_o); end
        drop_cmd();
    endtask

    task automatic test_wr_snoop();
        int cyc;
        cbus_addr_i = 32'h44; cbus_cmd_i = ENR; en_ready_i = 1'b1;
        wait_ack(10, cyc);
        en_ready_i = 1'b0;
        vectors++; if (cyc != 3) begin miscompares++; $display("FAIL enrd_fast_latency: got %0d want 3", cyc); end
        drop_cmd();
        cbus_addr_i = 32'h60; cbus_cmd_i = WRS;
        wait_ack(10, cyc);
        vectors++; if (cyc != 2) begin miscompares++; $display("FAIL wrs_miss_latency: got %0d want 2", cyc); end
        drop_cmd();
        dbg_addr_i = 32'h40; #1;
        vectors++; if (dbg_state_o !== 2'd1) begin miscompares++; $display("FAIL wrs_miss_keeps_40: got %0d want 1", dbg_state_o); end
        cbus_addr_i = 32'h40; cbus_cmd_i = WRS;
        wait_ack(10, cyc);
        vectors++; if (cyc != 2) begin miscompares++; $display("FAIL wrs_hit_latency: got %0d want 2", cyc); end
        vectors++; if (wb_req_o !== 1'b0) begin miscompares++; $display("FAIL wrs_hit_wb_req: got %b want 0", wb_req_o); end
        drop_cmd();
        dbg_addr_i = 32'h40; #1;
        vectors++; if (dbg_state_o !== 2'd0) begin miscompares++; $display("FAIL wrs_hit_state: got %0d want 0", dbg_state_o); end
        dbg_addr_i = 32'h44; #1;
        vectors++; if (dbg_state_o !== 2'd1) begin miscompares++; $display("FAIL wrs_other_index: got %0d want 1", dbg_state_o); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int cyc;
        cbus_addr_i = 32'h40; cbus_cmd_i = WRS;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cbus_ack_o === 1'b1) acks++;
        end
        vectors++; if (acks != 1) begin miscompares++; $display("FAIL held_cmd_acks: got %0d want 1", acks); end
        cbus_cmd_i = NOP;
        tick();
        cbus_cmd_i = ENR; en_ready_i = 1'b1;
        wait_ack(10, cyc);
        en_ready_i = 1'b0;
        vectors++; if (cyc != 3) begin miscompares++; $display("FAIL b2b_enrd_latency: got %0d want 3", cyc); end
        drop_cmd();
        dbg_addr_i = 32'h40; #1;
        vectors++; if (dbg_state_o !== 2'd1) begin miscompares++; $display("FAIL b2b_enrd_state: got %0d want 1", dbg_state_o); end
        vectors++; if (proto_err_o !== 1'b0) begin miscompares++; $display("FAIL b2b_proto_err: got %b want 0", proto_err_o); end
    endtask

    task automatic test_proto_err();
        cbus_cmd_i = 3'd6;
        tick();
        vectors++; if (proto_err_o !== 1'b1) begin miscompares++; $display("FAIL bad_code_err: got %b want 1", proto_err_o); end
        cbus_cmd_i = NOP;
        tick(); tick();
        vectors++; if (proto_err_o !== 1'b1 || cbus_ack_o !== 1'b0) begin miscompares++; $display("FAIL bad_code_sticky: got err=%b ack=%b want err=1 ack=0", proto_err_o, cbus_ack_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (proto_err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear_by_rst: got %b want 0", proto_err_o); end
        tick();
        cbus_addr_i = 32'h80; cbus_cmd_i = ENW;
        tick(); tick();
        vectors++; if (en_valid_o !== 1'b1 || proto_err_o !== 1'b0) begin miscompares++; $display("FAIL grant_pre: got valid=%b err=%b want valid=1 err=0", en_valid_o, proto_err_o); end
        cbus_cmd_i = ENR;
        tick();
        vectors++; if (proto_err_o !== 1'b1) begin miscompares++; $display("FAIL mid_grant_err: got %b want 1", proto_err_o); end
        vectors++; if (en_valid_o !== 1'b1 || en_wr_o !== 1'b1) begin miscompares++; $display("FAIL mid_grant_ignored: got valid=%b wr=%b want 1 1", en_valid_o, en_wr_o); end
        cbus_cmd_i = ENW; en_ready_i = 1'b1;
        tick();
        en_ready_i = 1'b0;
        vectors++; if (cbus_ack_o !== 1'b1) begin miscompares++; $display("FAIL mid_grant_ack: got %b want 1", cbus_ack_o); end
        dbg_addr_i = 32'h80; #1;
        vectors++; if (dbg_state_o !== 2'd3) begin miscompares++; $display("FAIL mid_grant_state: got %0d want 3", dbg_state_o); end
        drop_cmd();
    endtask

    task automatic test_reset_in_wb();
        int acks = 0;
        cbus_addr_i = 32'h80; cbus_cmd_i = RDS;
        tick(); tick();
        vectors++; if (wb_req_o !== 1'b1) begin miscompares++; $display("FAIL rstwb_pre_req: got %b want 1", wb_req_o); end
        rst = 1'b1; cbus_cmd_i = NOP;
        tick();
        dbg_addr_i = 32'h80; #1;
        vectors++; if (wb_req_o !== 1'b0 || cbus_ack_o !== 1'b0) begin miscompares++; $display("FAIL rstwb_outputs: got req=%b ack=%b want 0 0", wb_req_o, cbus_ack_o); end
        vectors++; if (proto_err_o !== 1'b0) begin miscompares++; $display("FAIL rstwb_proto_err: got %b want 0", proto_err_o); end
        vectors++; if (dbg_state_o !== 2'd0) begin miscompares++; $display("FAIL rstwb_table_clear: got %0d want 0", dbg_state_o); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cbus_ack_o === 1'b1) acks++;
        end
        vectors++; if (acks != 0) begin miscompares++; $display("FAIL rstwb_no_ack: got %0d want 0", acks); end
        vectors++; if (wb_req_o !== 1'b0) begin miscompares++; $display("FAIL rstwb_req_stays_low: got %b want 0", wb_req_o); end
    endtask

    initial begin
        test_reset();
        test_rd_snoop_miss();
        test_en_wr_grant();
        test_rd_snoop_wb();
        test_wr_snoop();
        test_back_to_back();
        test_proto_err();
        test_reset_in_wb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
